landing_scheduler: RTL and testbench

// Sequences the runway landing-light FSM: generates its step enable and selects the wind mode it sees.

---
 rtl/landing_scheduler_if.sv | 23 ++
 rtl/landing_scheduler.sv | 164 ++++++++++++++++
 tb/tb_landing_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/landing_scheduler_if.sv
// Signal bundle between the board/tower side and the landing scheduler.
// The master drives run/mode requests; the slave (scheduler) drives the light-FSM controls.
interface landing_scheduler_if;
    logic       run_en;
    logic [1:0] wind_mode;
    logic       tower_req;
    logic [1:0] tower_mode;
    logic [1:0] mode;
    logic       step;
    logic       owner;
    logic       grant;
    logic       bad_mode;

    modport master (
        output run_en, wind_mode, tower_req, tower_mode,
        input  mode, step, owner, grant, bad_mode
    );

    modport slave (
        input  run_en, wind_mode, tower_req, tower_mode,
        output mode, step, owner, grant, bad_mode
    );
endinterface

// File: rtl/landing_scheduler.sv
// Runway landing-light scheduler: step-enable divider plus wind/tower mode arbitration on step boundaries.
// Optional tower ownership timeout is enabled by defining TOWER_TIMEOUT_EN.
module landing_scheduler #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int MIN_DWELL     = 3,
    parameter int TOWER_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    landing_scheduler_if.slave  bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_MIN = DW'(MIN_DWELL);
    localparam logic [DW-1:0] DWELL_ONE = DW'(1);

    if (TICK_DIV < 2 || MIN_DWELL < 1 || TOWER_TIMEOUT < 1) begin : g_param_check
        $error("landing_scheduler: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN_WIND  = 2'd1,
        RUN_TOWER = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt, tick_next;
    logic [DW-1:0] dwell_cnt, dwell_next;
    logic          owner_q, owner_next;
    logic [1:0]    mode_q, mode_next;
    logic          grant_q, grant_next;
    logic          bad_q, bad_next;

    logic          running;
    logic          step_now;
    logic          cand;
    logic          force_release;
    logic [1:0]    src_mode;

`ifdef TOWER_TIMEOUT_EN
    localparam int TTW = $clog2(TOWER_TIMEOUT + 1);
    localparam logic [TTW-1:0] TEN_LIMIT = TTW'(TOWER_TIMEOUT);

    logic [TTW-1:0] ten_cnt, ten_next, ten_inc;
    logic           lock_q, lock_next;
`endif

    // State register and all step-synchronous datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            dwell_cnt <= '0;
            owner_q   <= 1'b0;
            mode_q    <= 2'b00;
            grant_q   <= 1'b0;
            bad_q     <= 1'b0;
`ifdef TOWER_TIMEOUT_EN
            ten_cnt   <= '0;
            lock_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state     <= state_next;
            tick_cnt  <= tick_next;
            dwell_cnt <= dwell_next;
            owner_q   <= owner_next;
            mode_q    <= mode_next;
            grant_q   <= grant_next;
            bad_q     <= bad_next;
`ifdef TOWER_TIMEOUT_EN
            ten_cnt   <= ten_next;
            lock_q    <= lock_next;
`endif
        end
    end

    // Next-state and arbitration logic.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_next    = state;
        dwell_next    = dwell_cnt;
        owner_next    = owner_q;
        mode_next     = mode_q;
        grant_next    = 1'b0;
        bad_next      = bad_q;
        cand          = bus.tower_req;
        force_release = 1'b0;
        src_mode      = 2'b00;
`ifdef TOWER_TIMEOUT_EN
        ten_next      = ten_cnt;
        lock_next     = lock_q;
        ten_inc       = ten_cnt + 1'b1;
`endif

        if (step_now) begin
`ifdef TOWER_TIMEOUT_EN
            // After a forced release the tower is shut out until it drops its request on a step.
            if (lock_q) cand = 1'b0;
            force_release = owner_q && (ten_inc == TEN_LIMIT);
`endif
            if (force_release)
                owner_next = 1'b0;
            else if (cand != owner_q && dwell_cnt >= DWELL_MIN)
                owner_next = cand;

            if (owner_next != owner_q) begin
                grant_next = 1'b1;
                dwell_next = DWELL_ONE;
            end else if (dwell_cnt < DWELL_MIN) begin
                dwell_next = dwell_cnt + 1'b1;
            end

            src_mode = owner_next ? bus.tower_mode : bus.wind_mode;
            if (src_mode == 2'b11) begin
                mode_next = 2'b00;
                bad_next  = 1'b1;
            end else begin
                mode_next = src_mode;
            end
`ifdef TOWER_TIMEOUT_EN
            if (owner_next != owner_q)
                ten_next = '0;
            else if (owner_q)
                ten_next = ten_inc;

            if (force_release)
                lock_next = 1'b1;
            else if (!bus.tower_req)
                lock_next = 1'b0;
`endif
        end

        unique case (state)
            IDLE: begin
                if (bus.run_en) state_next = owner_q ? RUN_TOWER : RUN_WIND;
            end
            RUN_WIND, RUN_TOWER: begin
                if (!bus.run_en) state_next = IDLE;
                else             state_next = owner_next ? RUN_TOWER : RUN_WIND;
            end
            default: state_next = IDLE;
        endcase

        // The divider only advances while running and staying in a RUN state.
        if (running && bus.run_en)
            tick_next = step_now ? '0 : tick_cnt + 1'b1;
        else
            tick_next = '0;
    end

    // Output logic.
    always_comb begin
        running      = (state == RUN_WIND) || (state == RUN_TOWER);
        step_now     = running && (tick_cnt == TICK_LAST);
        bus.step     = step_now;
        bus.mode     = mode_q;
        bus.owner    = owner_q;
        bus.grant    = grant_q;
        bus.bad_mode = bad_q;
    end
endmodule

// File: tb/tb_landing_scheduler.sv
// Self-checking bench for landing_scheduler: directed scenarios plus randomized traffic,
// compared every cycle against a step-level behavioural model.
`timescale 1ns/1ps
module tb_landing_scheduler;
    localparam int TICK_DIV      = 4;
    localparam int MIN_DWELL     = 2;
    localparam int TOWER_TIMEOUT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    landing_scheduler_if bus();

    landing_scheduler #(
        .TICK_DIV      (TICK_DIV),
        .MIN_DWELL     (MIN_DWELL),
        .TOWER_TIMEOUT (TOWER_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: running flag, cycles spent running, steps held by current owner.
    bit         m_run;
    int         m_phase;
    bit         m_owner;
    int         m_held;
    logic [1:0] m_mode;
    bit         m_grant;
    bit         m_bad;
    bit         m_lock;

    function automatic bit m_step_now();
        return m_run && (m_phase % TICK_DIV == TICK_DIV - 1);
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_phase = 0;
        m_owner = 1'b0;
        m_held  = 0;
        m_mode  = 2'b00;
        m_grant = 1'b0;
        m_bad   = 1'b0;
        m_lock  = 1'b0;
    endtask

    task automatic model_clock();
        bit         stepping;
        bit         want;
        bit         nxt;
        logic [1:0] src;
        stepping = m_step_now();
        m_grant  = 1'b0;
        if (stepping) begin
            want = bus.tower_req;
            nxt  = m_owner;
`ifdef TOWER_TIMEOUT_EN
            if (m_lock) want = 1'b0;
            if (m_owner && m_held == TOWER_TIMEOUT) begin
                nxt    = 1'b0;
                m_lock = 1'b1;
            end else begin
                if (want != m_owner && m_held >= MIN_DWELL) nxt = want;
                if (!bus.tower_req) m_lock = 1'b0;
            end
`else
            if (want != m_owner && m_held >= MIN_DWELL) nxt = want;
`endif
            if (nxt != m_owner) begin
                m_grant = 1'b1;
                m_held  = 1;
            end else begin
                m_held++;
            end
            m_owner = nxt;
            src = nxt ? bus.tower_mode : bus.wind_mode;
            if (src == 2'b11) begin
                m_mode = 2'b00;
                m_bad  = 1'b1;
            end else begin
                m_mode = src;
            end
        end
        if (m_run) begin
            if (bus.run_en) m_phase++;
            else            m_run = 1'b0;
        end else if (bus.run_en) begin
            m_run   = 1'b1;
            m_phase = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_clock();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("step",     bus.step,     m_step_now());
            check("mode",     bus.mode,     m_mode);
            check("owner",    bus.owner,    m_owner);
            check("grant",    bus.grant,    m_grant);
            check("bad_mode", bus.bad_mode, m_bad);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_step(input int limit, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!bus.step && n < limit);
    endtask

    task automatic wait_grant(input int limit, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!bus.grant && n < limit);
    endtask

    initial begin
        int n;
        bit saw;
        int tower_steps;
        bus.run_en     = 1'b0;
        bus.wind_mode  = 2'b00;
        bus.tower_req  = 1'b0;
        bus.tower_mode = 2'b00;
        #1 rst_n = 1'b0;
        cyc(3);
        check("rst_mode",  bus.mode,     0);
        check("rst_owner", bus.owner,    0);
        check("rst_step",  bus.step,     0);
        check("rst_grant", bus.grant,    0);
        check("rst_bad",   bus.bad_mode, 0);

        // First step four cycles after run_en, wind mode adopted.
        rst_n         = 1'b1;
        bus.run_en    = 1'b1;
        bus.wind_mode = 2'b01;
        wait_step(20, n);
        check("first_step_latency", n, 4);
        cyc(1);
        check("wind_mode_taken", bus.mode, 2'b01);
        check("wind_owner", bus.owner, 0);

        // Tower request: granted on the first step with dwell satisfied (third step).
        bus.tower_req  = 1'b1;
        bus.tower_mode = 2'b10;
        wait_grant(30, n);
        check("tower_grant_latency", n, 8);
        check("tower_owner", bus.owner, 1);
        check("tower_mode_taken", bus.mode, 2'b10);
        cyc(1);
        check("grant_one_cycle", bus.grant, 0);

        // Tower drops early: ownership kept until dwell is met.
        bus.tower_req = 1'b0;
        wait_grant(20, n);
        check("release_latency", n, 7);
        check("released_owner", bus.owner, 0);
        check("released_mode", bus.mode, 2'b01);

        // Short tower pulse between steps is ignored.
        cyc(8);
        bus.tower_req = 1'b1;
        cyc(2);
        bus.tower_req = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (bus.grant) saw = 1'b1;
        end
        check("pulse_no_grant", saw, 0);
        check("pulse_owner", bus.owner, 0);

        // Freeze: no steps while run_en is low, outputs held.
        bus.run_en = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.step) saw = 1'b1;
        end
        check("frozen_no_step", saw, 0);
        check("frozen_mode", bus.mode, 2'b01);
        check("frozen_owner", bus.owner, 0);
        bus.run_en = 1'b1;
        wait_step(20, n);
        check("resume_latency", n, 4);

        // Illegal sensor mode: forced to calm and flagged stickily.
        bus.wind_mode = 2'b11;
        wait_step(10, n);
        cyc(1);
        check("illegal_mode_calm", bus.mode, 2'b00);
        check("illegal_flag", bus.bad_mode, 1);
        bus.wind_mode = 2'b00;
        cyc(8);
        check("flag_sticky", bus.bad_mode, 1);

`ifdef TOWER_TIMEOUT_EN
        // Tower timeout: three steps of ownership, then locked out until request drops on a step.
        bus.tower_req  = 1'b1;
        bus.tower_mode = 2'b01;
        wait_grant(40, n);
        check("to_owner", bus.owner, 1);
        tower_steps = 0;
        n = 0;
        do begin
            cyc(1);
            n++;
            if (bus.step && bus.owner) tower_steps++;
        end while (!bus.grant && n < 60);
        check("to_steps", tower_steps, TOWER_TIMEOUT);
        check("to_released", bus.owner, 0);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus.grant) saw = 1'b1;
        end
        check("to_locked", saw, 0);
        bus.tower_req = 1'b0;
        cyc(4);
        bus.tower_req = 1'b1;
        wait_grant(20, n);
        check("to_regrant", bus.owner, 1);
`else
        tower_steps = 0;
`endif

        // Randomized traffic including async resets mid-step.
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            if ($urandom_range(0, 99) < 1) begin
                rst_n = 1'b0;
                cyc($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 99) < 4) bus.run_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 15) bus.tower_req = ~bus.tower_req;
            if ($urandom_range(0, 99) < 10)
                bus.wind_mode = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 99) < 10)
                bus.tower_mode = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
